// File: rtl/top_alu.sv
// top_alu: registered integer ALU for the core's execution stage.
// Computes one of twelve arithmetic/logic/modulo/compare operations on two
// WIDTH-bit operands; result and status flags are registered (1-cycle latency).
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears all outputs)
//   a, b     WIDTH-bit operands
//   sel      4-bit opcode
//   out      registered result
//   zero     result is zero on a valid op (never set alongside error)
//   carry    carry out for ADD, borrow for SUB, else 0
//   overflow two's-complement overflow for ADD/SUB, else 0
//   error    invalid opcode or modulo by zero
//
// Build option: define ALU_MODULO_EN to build the modulo unit (opcode 1000);
// without it, opcode 1000 is treated as an invalid opcode.
module top_alu #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             error
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_NAND = 4'b0110,
    OP_XNOR = 4'b0111,
    OP_MOD  = 4'b1000,
    OP_EQU  = 4'b1001,
    OP_GT   = 4'b1010,
    OP_LT   = 4'b1011
  } op_e;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;
  logic             res_err;
  logic             res_zero;

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (sel)
      OP_ADD: begin
        {res_carry, res} = {1'b0, a} + {1'b0, b};
        res_ovf = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res       = a - b;
        res_carry = (a < b);
        res_ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_NAND: res = ~(a & b);
      OP_XNOR: res = ~(a ^ b);
      OP_MOD: begin
`ifdef ALU_MODULO_EN
        if (b == '0) res_err = 1'b1;
        else         res     = a % b;
`else
        res_err = 1'b1;
`endif
      end
      OP_EQU:  res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_GT:   res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LT:   res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: res_err = 1'b1;
    endcase
    // error paths leave res at 0, so zero must be masked explicitly
    res_zero = !res_err && (res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      out      <= res;
      zero     <= res_zero;
      carry    <= res_carry;
      overflow <= res_ovf;
      error    <= res_err;
    end
  end

endmodule

// File: tb/tb_top_alu.sv
// tb_top_alu: self-checking bench for top_alu (directed plan plus random ops
// checked against an integer-arithmetic reference model).
module tb_top_alu;

  localparam int          WIDTH = 2;
  localparam int unsigned M     = 1 << WIDTH;
  localparam int          VW    = WIDTH + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a, b, out;
  logic [3:0]       sel;
  logic             zero, carry, overflow, error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  top_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .out(out), .zero(zero), .carry(carry), .overflow(overflow), .error(error)
  );

  function automatic int to_signed(input int unsigned v);
    return (v >= M/2) ? int'(v) - int'(M) : int'(v);
  endfunction

  function automatic bit out_of_range(input int r);
    return (r < -int'(M/2)) || (r > int'(M/2) - 1);
  endfunction

  // Expected {out, zero, carry, overflow, error} from plain integer arithmetic.
  function automatic logic [VW-1:0] model(input int unsigned av, input int unsigned bv,
                                          input int unsigned s);
    int unsigned o = 0;
    bit c = 0, v = 0, e = 0;
    case (s)
      0: begin o = (av + bv) % M; c = (av + bv) >= M;
               v = out_of_range(to_signed(av) + to_signed(bv)); end
      1: begin o = (av + M - bv) % M; c = av < bv;
               v = out_of_range(to_signed(av) - to_signed(bv)); end
      2: o = av & bv;
      3: o = av | bv;
      4: o = av ^ bv;
      5: o = ~(av | bv) & (M - 1);
      6: o = ~(av & bv) & (M - 1);
      7: o = ~(av ^ bv) & (M - 1);
      8: begin
`ifdef ALU_MODULO_EN
        if (bv == 0) e = 1; else o = av % bv;
`else
        e = 1;
`endif
      end
      9:  o = (av == bv) ? 1 : 0;
      10: o = (av > bv) ? 1 : 0;
      11: o = (av < bv) ? 1 : 0;
      default: e = 1;
    endcase
    return {o[WIDTH-1:0], (!e && o == 0), c, v, e};
  endfunction

  task automatic apply(input logic r, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic [3:0] xs, input logic [VW-1:0] exp, input string tag);
    rst = r; a = xa; b = xb; sel = xs;
    @(posedge clk);
    #1;
    vectors++;
    assert ({out, zero, carry, overflow, error} === exp)
    else begin
      miscompares++;
      $error("FAIL %s: a=%b b=%b sel=%b observed out/z/c/v/e=%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
             tag, xa, xb, xs, out, zero, carry, overflow, error,
             exp[VW-1:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic dir(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic [3:0] xs,
                     input logic [WIDTH-1:0] eo, input logic ez, input logic ec,
                     input logic ev, input logic ee, input string tag);
    apply(1'b0, xa, xb, xs, {eo, ez, ec, ev, ee}, tag);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [3:0]       rs;
    logic             rr;

    // reset held two cycles with arbitrary inputs
    apply(1'b1, 2'b11, 2'b01, 4'b0000, '0, "reset0");
    apply(1'b1, 2'b10, 2'b00, 4'b1111, '0, "reset1");
    dir(2'b01, 2'b01, 4'b0000, 2'b10, 0, 0, 1, 0, "add_01_01");
    dir(2'b11, 2'b01, 4'b0000, 2'b00, 1, 1, 0, 0, "add_wrap");
    dir(2'b11, 2'b01, 4'b0001, 2'b10, 0, 0, 0, 0, "sub_11_01");
    dir(2'b11, 2'b01, 4'b0010, 2'b01, 0, 0, 0, 0, "and");
    dir(2'b10, 2'b01, 4'b0011, 2'b11, 0, 0, 0, 0, "or");
    dir(2'b10, 2'b01, 4'b0100, 2'b11, 0, 0, 0, 0, "xor");
    dir(2'b00, 2'b00, 4'b0101, 2'b11, 0, 0, 0, 0, "nor");
    dir(2'b11, 2'b01, 4'b0110, 2'b10, 0, 0, 0, 0, "nand");
    dir(2'b10, 2'b01, 4'b0111, 2'b00, 1, 0, 0, 0, "xnor");
`ifdef ALU_MODULO_EN
    dir(2'b11, 2'b01, 4'b1000, 2'b00, 1, 0, 0, 0, "mod_11_01");
    dir(2'b11, 2'b10, 4'b1000, 2'b01, 0, 0, 0, 0, "mod_11_10");
    dir(2'b10, 2'b00, 4'b1000, 2'b00, 0, 0, 0, 1, "mod_by_zero");
`else
    dir(2'b11, 2'b10, 4'b1000, 2'b00, 0, 0, 0, 1, "mod_disabled");
`endif
    dir(2'b11, 2'b10, 4'b1001, 2'b00, 1, 0, 0, 0, "equ_ne");
    dir(2'b11, 2'b11, 4'b1001, 2'b01, 0, 0, 0, 0, "equ_eq");
    dir(2'b11, 2'b01, 4'b1010, 2'b01, 0, 0, 0, 0, "gt_true");
    dir(2'b00, 2'b01, 4'b1010, 2'b00, 1, 0, 0, 0, "gt_false");
    dir(2'b00, 2'b01, 4'b1011, 2'b01, 0, 0, 0, 0, "lt_true");
    dir(2'b10, 2'b01, 4'b1011, 2'b00, 1, 0, 0, 0, "lt_false");
    dir(2'b11, 2'b11, 4'b1111, 2'b00, 0, 0, 0, 1, "invalid");
    dir(2'b10, 2'b01, 4'b0010, 2'b00, 1, 0, 0, 0, "after_invalid");
    dir(2'b11, 2'b11, 4'b1100, 2'b00, 0, 0, 0, 1, "invalid_1100");
    // mid-stream reset discards that cycle's op, next op one cycle later
    dir(2'b11, 2'b01, 4'b0000, 2'b00, 1, 1, 0, 0, "pre_reset");
    apply(1'b1, 2'b01, 2'b01, 4'b0000, '0, "midreset");
    dir(2'b01, 2'b01, 4'b0000, 2'b10, 0, 0, 1, 0, "post_reset");

    for (int i = 0; i < 400; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 4'($urandom);
      rr = ($urandom_range(0, 19) == 0);
      apply(rr, ra, rb, rs, rr ? '0 : model(ra, rb, rs), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/top_alu.md
# top_alu

Small registered integer ALU used as the datapath execution unit of the RISC-style core. It takes two WIDTH-bit operands and a 4-bit opcode and performs one of twelve arithmetic, logic, modulo or compare operations. It produces a registered result plus zero, carry, overflow and error status flags one clock later.

## Interface
- WIDTH, default 2: operand and result width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  4  opcode.
- out  output  WIDTH  registered result.
- zero  output  1  registered; 1 when the result is zero on a valid op.
- carry  output  1  registered; carry out for ADD, borrow for SUB.
- overflow  output  1  registered two's-complement overflow for ADD and SUB.
- error  output  1  registered; 1 for an invalid opcode or modulo by zero.
- One clock; reset is synchronous and active-high.

## Operation
- Opcode encoding:
  - 0000 ADD: out = a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = a[MSB]==b[MSB] && out[MSB]!=a[MSB].
  - 0001 SUB: out = a-b mod 2^WIDTH; carry = (a<b) unsigned, i.e. borrow; overflow = a[MSB]!=b[MSB] && out[MSB]!=a[MSB].
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 NAND, 0111 XNOR: bitwise over all WIDTH bits.
  - 1000 MODULO: out = a % b, unsigned.
  - 1001 EQU: out = (a==b).
  - 1010 GREATER_THAN: out = (a>b), unsigned.
  - 1011 LESS_THAN: out = (a<b), unsigned.
- Compare results: true = 1, false = 0, zero-extended to WIDTH.
- carry and overflow are 0 for every opcode other than ADD and SUB.
- zero = (out==0) on valid ops; zero = 0 whenever error = 1.
- Invalid opcodes (1100–1111): out=0, carry=0, overflow=0, zero=0, error=1.
- Modulo by zero (b==0): out=0, all flags 0, error=1.
- error = 0 for every other case.

## Timing
- Fully combinational compute; all five outputs are registered on the rising edge of clk.
- Latency is 1 cycle: outputs reflect the a, b, sel sampled at the previous edge.
- Throughput is one operation per cycle. No handshake; a new op is accepted every edge.
- When rst=1 at an edge, all outputs become 0: out=0, zero=0, carry=0, overflow=0, error=0. Inputs at that edge are discarded.
- Reset asserted mid-stream takes priority over that cycle's operation. The first op after deassertion appears one cycle later.

## Configuration
- ALU_MODULO_EN defined: opcode 1000 performs MODULO as specified.
- ALU_MODULO_EN undefined: no divider logic is built, and opcode 1000 is treated as an invalid opcode (error=1, out=0, flags 0).

## Test plan
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> all outputs 0; release, ADD 01+01 -> next cycle out=10, overflow=1, carry=0, zero=0.
- ADD with wrap: a=11, b=01, sel=0000 -> out=00, carry=1, zero=1, overflow=0; SUB a=11, b=01 -> out=10, all flags 0.
- Logic ops, sel=0010..0111:
  - AND 11,01 -> 01.
  - OR 10,01 -> 11.
  - XOR 10,01 -> 11.
  - NOR 00,00 -> 11.
  - NAND 11,01 -> 10.
  - XNOR 10,01 -> 00 with zero=1.
- Modulo (macro on): 11%01 -> 00, zero=1; 11%10 -> 01; 10%00 -> error=1, out=00. With macro off: sel=1000 -> error=1.
- Compares:
  - EQU 11,10 -> 00, zero=1.
  - EQU 11,11 -> 01.
  - GT 11,01 -> 01.
  - GT 00,01 -> 00.
  - LT 00,01 -> 01.
  - LT 10,01 -> 00, zero=1.
- Invalid/back-to-back: sel=1111 -> error=1, out=00; next cycle AND 10,01 -> error=0, out=00, zero=1. Each result appears exactly one cycle after its inputs.
